// File: rtl/hic_pkg.sv
// Shared mode encodings, expiry-state enumeration and default widths for the
// cascadable HIC down-counting stage.
package hic_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int MODE_W_DEF = 2;

    localparam logic [1:0] MODE_HOLD   = 2'd0;
    localparam logic [1:0] MODE_DEC    = 2'd1;
    localparam logic [1:0] MODE_RELOAD = 2'd2;
    localparam logic [1:0] MODE_LOAD   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/hic_down_ctrl.sv
// Expiry state machine and sticky done flag for one down-counting stage,
// plus the zero-latency borrow-out used by the ripple cascade.
module hic_down_ctrl
    import hic_pkg::*;
#(
    parameter int MODE_W = MODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] m,
    input  logic              bin,
    input  logic              pin_zero,
    input  logic              cnt_zero,
    input  logic              cnt_one,
    output logic              bout,
    output logic              done
);

    state_t state;

    // Borrow is suppressed during reset so a downstream stage never sees a
    // spurious enable while the chain is being cleared.
    assign bout = ~rst & bin & ((m == MODE_DEC) | (m == MODE_RELOAD)) & cnt_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (m)
                MODE_LOAD: begin
                    done  <= 1'b0;
                    state <= pin_zero ? EXPIRED : ARMED;
                end
                MODE_DEC: begin
                    // Expiry is judged on the pre-decrement count; an unloaded
                    // (IDLE) stage free-runs without ever flagging.
                    if (bin && cnt_one && (state != IDLE)) begin
                        state <= EXPIRED;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                    done  <= done;
                end
            endcase
        end
    end

endmodule

// File: rtl/hic_down_stage.sv
// Cascadable down-counting stage: borrow-chain counterpart of the HIC up-counter,
// with parallel load, auto-reload mode and a sticky expiry flag.
module hic_down_stage
    import hic_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int MODE_W = MODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bin,
    input  logic [WIDTH-1:0]  pin,
    input  logic [MODE_W-1:0] m,
    output logic              bout,
    output logic [WIDTH-1:0]  fout,
    output logic [MODE_W-1:0] mo,
    output logic              done
);

    logic cnt_zero;
    logic cnt_one;
    logic pin_zero;

    assign cnt_zero = (fout == '0);
    assign cnt_one  = (fout == WIDTH'(1));
    assign pin_zero = (pin == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fout <= '0;
            mo   <= '0;
        end else begin
            mo <= m;
            case (m)
                MODE_LOAD:   fout <= pin;
                MODE_DEC:    if (bin) fout <= fout - WIDTH'(1);
                MODE_RELOAD: if (bin) fout <= cnt_zero ? pin : fout - WIDTH'(1);
                MODE_HOLD:   fout <= fout;
                default:     fout <= fout;
            endcase
        end
    end

    hic_down_ctrl #(
        .MODE_W (MODE_W)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .m        (m),
        .bin      (bin),
        .pin_zero (pin_zero),
        .cnt_zero (cnt_zero),
        .cnt_one  (cnt_one),
        .bout     (bout),
        .done     (done)
    );

endmodule

// File: tb/tb_hic_down_stage.sv
// Directed bench for hic_down_stage: reset, decrement to expiry, wrap,
// auto-reload, reset-over-load and a two-stage borrow cascade.
module tb_hic_down_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       bin;
    logic [7:0] pin;
    logic [1:0] m;
    logic       bout;
    logic [7:0] fout;
    logic [1:0] mo;
    logic       done;

    logic [1:0] cm;
    logic [7:0] cpin;
    logic       c0_bout, c1_bout;
    logic [7:0] c0_fout, c1_fout;
    logic [1:0] c0_mo, c1_mo;
    logic       c0_done, c1_done;

    int vectors    = 0;
    int miscompares = 0;
    int exp_r [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
    logic seen_done;

    always #5 clk = ~clk;

    hic_down_stage u_dut (
        .clk  (clk), .rst (rst), .bin (bin), .pin (pin), .m (m),
        .bout (bout), .fout (fout), .mo (mo), .done (done)
    );

    hic_down_stage u_c0 (
        .clk  (clk), .rst (rst), .bin (1'b1), .pin (cpin), .m (cm),
        .bout (c0_bout), .fout (c0_fout), .mo (c0_mo), .done (c0_done)
    );

    hic_down_stage u_c1 (
        .clk  (clk), .rst (rst), .bin (c0_bout), .pin (cpin), .m (cm),
        .bout (c1_bout), .fout (c1_fout), .mo (c1_mo), .done (c1_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; m = 2'd1; bin = 1'b1; pin = 8'd0;
        cm = 2'd0; cpin = 8'd0;

        // Reset with decrement requested: count clears and borrow stays low.
        step();
        check("rst_fout", fout, 0);
        check("rst_mo", mo, 0);
        check("rst_done", done, 0);
        check("rst_bout", bout, 0);
        rst = 1'b0; m = 2'd0;
        #1;
        check("hold_bout", bout, 0);
        step();
        check("hold_fout", fout, 0);
        check("hold_mo", mo, 0);

        // Load 10 and count down to expiry.
        m = 2'd3; pin = 8'd10;
        step();
        check("load_fout", fout, 10);
        check("load_mo", mo, 3);
        check("load_done", done, 0);
        m = 2'd1; bin = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("dec_fout_%0d", i), fout, 10 - i);
            check($sformatf("dec_mo_%0d", i), mo, 1);
            check($sformatf("dec_done_%0d", i), done, (i == 10) ? 1 : 0);
            check($sformatf("dec_bout_%0d", i), bout, (i == 10) ? 1 : 0);
        end

        // Underflow wraps; done stays sticky.
        step();
        check("wrap_fout", fout, 255);
        check("wrap_done", done, 1);
        check("wrap_bout", bout, 0);

        // Load 3, then auto-reload.
        m = 2'd3; pin = 8'd3;
        step();
        check("ld3_fout", fout, 3);
        check("ld3_done", done, 0);
        m = 2'd2;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rl_fout_%0d", i), fout, exp_r[i]);
            check($sformatf("rl_bout_%0d", i), bout, (exp_r[i] == 0) ? 1 : 0);
            check($sformatf("rl_done_%0d", i), done, 0);
        end

        // Decrement mode without borrow-in holds.
        m = 2'd1; bin = 1'b0;
        step();
        check("nobin_fout", fout, 3);
        check("nobin_mo", mo, 1);

        // Reset beats a simultaneous load mid-count.
        m = 2'd3; pin = 8'd10; bin = 1'b1;
        step();
        m = 2'd1;
        step(); step(); step();
        check("mid_fout", fout, 7);
        rst = 1'b1; m = 2'd3; pin = 8'd5;
        step();
        check("rstld_fout", fout, 0);
        check("rstld_done", done, 0);
        check("rstld_mo", mo, 0);

        // Back in IDLE: a full 256-count lap never raises done.
        rst = 1'b0; m = 2'd1; bin = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (done !== 1'b0) seen_done = 1'b1;
        end
        check("idle_lap_done", seen_done, 0);
        check("idle_lap_fout", fout, 0);

        // Two-stage cascade: 0x0101 -> 0x0100 -> 0x00FF.
        m = 2'd0;
        cm = 2'd3; cpin = 8'h01;
        step();
        check("chain_load", {c1_fout, c0_fout}, 16'h0101);
        cm = 2'd1;
        step();
        check("chain_e1", {c1_fout, c0_fout}, 16'h0100);
        check("chain_e1_borrow", c0_bout, 1);
        step();
        check("chain_e2", {c1_fout, c0_fout}, 16'h00FF);
        check("chain_e2_mo", c1_mo, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
